// File: rtl/dds_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : dds_pkg                                                   |
// | Purpose  : Shared sweep-mode and state encodings for the DDS sweep   |
// |            controller and its helpers.                               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package dds_pkg;

  // Tuning-word width of the downstream sine DDS core
  localparam int DEFAULT_WIDTH = 32;

  // Sweep mode encodings (2'b11 is reserved and behaves as single-shot)
  localparam logic [1:0] SWEEP_SINGLE = 2'b00;
  localparam logic [1:0] SWEEP_SAW    = 2'b01;
  localparam logic [1:0] SWEEP_TRI    = 2'b10;

  // Controller states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sweep_state_t;

endpackage : dds_pkg
`default_nettype wire

// File: rtl/sweep_dwell_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sweep_dwell_timer                                         |
// | Purpose  : Dwell counter; pulses expire on the last cycle a tuning   |
// |            word is held, then restarts from zero.                    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sweep_dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic [DWELL_W-1:0] dwell,
  output logic               expire
);

  logic [DWELL_W-1:0] count;
  logic               at_limit;

  assign at_limit = (count == dwell);
  assign expire   = enable && at_limit;

  // Count hold cycles; wrap to zero on the final cycle of the dwell period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (at_limit) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule : sweep_dwell_timer
`default_nettype wire

// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dds_sweep_ctrl                                            |
// | Purpose  : Steps the DDS phase increment between two endpoints with  |
// |            a programmable dwell; single, sawtooth and triangle modes.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   start_step,
  input  logic [WIDTH-1:0]   stop_step,
  input  logic [WIDTH-1:0]   delta,
  input  logic [DWELL_W-1:0] dwell,
  output logic [WIDTH-1:0]   Step,
  output logic               busy,
  output logic               done,
  output logic               dir
);

  sweep_state_t       state;
  logic [WIDTH-1:0]   start_lat;
  logic [WIDTH-1:0]   stop_lat;
  logic [WIDTH-1:0]   delta_lat;
  logic [DWELL_W-1:0] dwell_lat;
  logic [1:0]         mode_lat;

  logic               accept;
  logic               timer_clear;
  logic               timer_en;
  logic               expire;
  logic               ascending;
  logic               moving_up;
  logic [WIDTH-1:0]   target;
  logic [WIDTH-1:0]   other_end;
  logic               at_target;
  logic [WIDTH-1:0]   fwd_val;
  logic [WIDTH-1:0]   turn_val;

  // One step from cur toward tgt, computed one bit wider so carry/borrow
  // is visible; anything that reaches or passes tgt lands exactly on tgt.
  function automatic logic [WIDTH-1:0] next_val(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] inc,
    input logic [WIDTH-1:0] tgt,
    input logic             up
  );
    logic [WIDTH:0] wide;
    logic [WIDTH-1:0] res;
    if (up) begin
      wide = {1'b0, cur} + {1'b0, inc};
      res  = (wide >= {1'b0, tgt}) ? tgt : wide[WIDTH-1:0];
    end else begin
      wide = {1'b0, cur} - {1'b0, inc};
      res  = (wide[WIDTH] || (wide[WIDTH-1:0] <= tgt)) ? tgt : wide[WIDTH-1:0];
    end
    return res;
  endfunction

  assign accept      = (state == ST_IDLE) && start && !abort;
  assign timer_en    = (state == ST_RUN);
  assign timer_clear = accept || ((state == ST_RUN) && abort);

  // Polarity is fixed by the latched endpoints; dir only reverses it
  assign ascending = (start_lat <= stop_lat);
  assign moving_up = ascending ^ dir;
  assign target    = dir ? start_lat : stop_lat;
  assign other_end = dir ? stop_lat : start_lat;
  assign at_target = (Step == target);

  // At a triangle turnaround the endpoint was already held for a full dwell,
  // so the first step toward the opposite endpoint is taken immediately.
  assign fwd_val  = next_val(Step, delta_lat, target, moving_up);
  assign turn_val = next_val(Step, delta_lat, other_end, !moving_up);

  sweep_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .dwell  (dwell_lat),
    .expire (expire)
  );

  // Sweep state machine with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      Step      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dir       <= 1'b0;
      start_lat <= '0;
      stop_lat  <= '0;
      delta_lat <= '0;
      dwell_lat <= '0;
      mode_lat  <= SWEEP_SINGLE;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            start_lat <= start_step;
            stop_lat  <= stop_step;
            delta_lat <= delta;
            dwell_lat <= dwell;
            mode_lat  <= mode;
            Step      <= start_step;
            busy      <= 1'b1;
            dir       <= 1'b0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (expire) begin
            if (at_target) begin
              case (mode_lat)
                SWEEP_SAW: begin
                  Step <= start_lat;
                end
                SWEEP_TRI: begin
                  dir  <= !dir;
                  Step <= turn_val;
                end
                default: begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
                end
              endcase
            end else begin
              Step <= fwd_val;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : dds_sweep_ctrl
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_dds_sweep_ctrl                                         |
// | Purpose  : Directed self-checking bench for dds_sweep_ctrl.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_dds_sweep_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic [31:0] start_step;
  logic [31:0] stop_step;
  logic [31:0] delta;
  logic [15:0] dwell;
  logic [31:0] Step;
  logic        busy;
  logic        done;
  logic        dir;

  int checks   = 0;
  int failures = 0;

  dds_sweep_ctrl #(
    .WIDTH   (32),
    .DWELL_W (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .start_step (start_step),
    .stop_step  (stop_step),
    .delta      (delta),
    .dwell      (dwell),
    .Step       (Step),
    .busy       (busy),
    .done       (done),
    .dir        (dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start pulse with the given sweep settings
  task automatic go(input logic [1:0] m, input logic [31:0] s, input logic [31:0] e,
                    input logic [31:0] d, input logic [15:0] dw);
    mode       = m;
    start_step = s;
    stop_step  = e;
    delta      = d;
    dwell      = dw;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Expect Step=v with busy high, no done and the given dir for n cycles
  task automatic expect_run(input string tag, input logic [31:0] v, input int n, input logic dr);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_step"}, Step, v);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_dir"},  {31'd0, dir},  {31'd0, dr});
      tick();
    end
  endtask

  task automatic expect_done(input string tag, input logic [31:0] v);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_step"}, Step, v);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00;
    start_step = '0; stop_step = '0; delta = '0; dwell = '0;
    #12;
    chk("rst_step", Step, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dir",  {31'd0, dir},  32'd0);
    reset = 1'b1;
    tick(); tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Single ascending, dwell 2
    go(2'b00, 32'd1000, 32'd1300, 32'd100, 16'd2);
    expect_run("s1_1000", 32'd1000, 3, 1'b0);
    expect_run("s1_1100", 32'd1100, 3, 1'b0);
    expect_run("s1_1200", 32'd1200, 3, 1'b0);
    expect_run("s1_1300", 32'd1300, 3, 1'b0);
    expect_done("s1_end", 32'd1300);
    tick();
    chk("s1_done_once", {31'd0, done}, 32'd0);
    chk("s1_hold", Step, 32'd1300);

    // Ascending clamp
    go(2'b00, 32'd0, 32'd250, 32'd100, 16'd0);
    expect_run("cl_0", 32'd0, 1, 1'b0);
    expect_run("cl_100", 32'd100, 1, 1'b0);
    expect_run("cl_200", 32'd200, 1, 1'b0);
    expect_run("cl_250", 32'd250, 1, 1'b0);
    expect_done("cl_end", 32'd250);

    // Descending
    go(2'b00, 32'd500, 32'd100, 32'd200, 16'd0);
    expect_run("de_500", 32'd500, 1, 1'b0);
    expect_run("de_300", 32'd300, 1, 1'b0);
    expect_run("de_100", 32'd100, 1, 1'b0);
    expect_done("de_end", 32'd100);

    // Overflow guard
    go(2'b00, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd0);
    expect_run("ov_a", 32'hFFFF_FF00, 1, 1'b0);
    expect_run("ov_b", 32'hFFFF_FF80, 1, 1'b0);
    expect_run("ov_c", 32'hFFFF_FFFF, 1, 1'b0);
    expect_done("ov_end", 32'hFFFF_FFFF);

    // Reserved mode behaves as single-shot
    go(2'b11, 32'd10, 32'd30, 32'd10, 16'd0);
    expect_run("rs_10", 32'd10, 1, 1'b0);
    expect_run("rs_20", 32'd20, 1, 1'b0);
    expect_run("rs_30", 32'd30, 1, 1'b0);
    expect_done("rs_end", 32'd30);

    // Equal endpoints, single-shot finishes after one dwell
    go(2'b00, 32'd77, 32'd77, 32'd5, 16'd1);
    expect_run("eq_77", 32'd77, 2, 1'b0);
    expect_done("eq_end", 32'd77);

    // Triangle then abort
    go(2'b10, 32'd10, 32'd30, 32'd10, 16'd0);
    expect_run("tr_10a", 32'd10, 1, 1'b0);
    expect_run("tr_20a", 32'd20, 1, 1'b0);
    expect_run("tr_30a", 32'd30, 1, 1'b0);
    expect_run("tr_20b", 32'd20, 1, 1'b1);
    expect_run("tr_10b", 32'd10, 1, 1'b1);
    expect_run("tr_20c", 32'd20, 1, 1'b0);
    expect_run("tr_30b", 32'd30, 1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("tr_ab_busy", {31'd0, busy}, 32'd0);
    chk("tr_ab_step", Step, 32'd20);
    chk("tr_ab_done", {31'd0, done}, 32'd0);

    // Sawtooth then abort at 20
    go(2'b01, 32'd10, 32'd30, 32'd10, 16'd0);
    expect_run("sw_10a", 32'd10, 1, 1'b0);
    expect_run("sw_20a", 32'd20, 1, 1'b0);
    expect_run("sw_30a", 32'd30, 1, 1'b0);
    expect_run("sw_10b", 32'd10, 1, 1'b0);
    expect_run("sw_20b", 32'd20, 1, 1'b0);
    expect_run("sw_30b", 32'd30, 1, 1'b0);
    expect_run("sw_10c", 32'd10, 1, 1'b0);
    chk("sw_pre_ab", Step, 32'd20);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("sw_ab_busy", {31'd0, busy}, 32'd0);
    chk("sw_ab_step", Step, 32'd20);
    chk("sw_ab_done", {31'd0, done}, 32'd0);
    tick();
    chk("sw_ab_done2", {31'd0, done}, 32'd0);
    chk("sw_ab_busy2", {31'd0, busy}, 32'd0);

    // Start together with abort in IDLE stays idle
    mode = 2'b00; start_step = 32'd999; stop_step = 32'd1999; delta = 32'd1; dwell = 16'd0;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", {31'd0, busy}, 32'd0);
    chk("sa_step", Step, 32'd20);
    tick();
    chk("sa_busy2", {31'd0, busy}, 32'd0);

    // Start during RUN is ignored, new inputs have no effect
    go(2'b00, 32'd10, 32'd30, 32'd10, 16'd0);
    chk("sr_10", Step, 32'd10);
    start = 1'b1; start_step = 32'd500; stop_step = 32'd600; delta = 32'd50; mode = 2'b01;
    tick();
    start = 1'b0;
    chk("sr_20", Step, 32'd20);
    chk("sr_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("sr_30", Step, 32'd30);
    tick();
    expect_done("sr_end", 32'd30);

    // Zero delta with distinct endpoints holds start value until abort
    go(2'b01, 32'd5, 32'd50, 32'd0, 16'd1);
    expect_run("dz_5", 32'd5, 6, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("dz_busy", {31'd0, busy}, 32'd0);
    chk("dz_step", Step, 32'd5);
    chk("dz_done", {31'd0, done}, 32'd0);

    // Asynchronous reset mid-sweep while descending in triangle mode
    go(2'b10, 32'd10, 32'd30, 32'd10, 16'd0);
    tick(); tick(); tick();
    chk("ar_pre_dir", {31'd0, dir}, 32'd1);
    chk("ar_pre_step", Step, 32'd20);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_step", Step, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_done", {31'd0, done}, 32'd0);
    chk("ar_dir",  {31'd0, dir},  32'd0);
    reset = 1'b1;
    tick();
    chk("ar_rel_busy", {31'd0, busy}, 32'd0);
    chk("ar_rel_step", Step, 32'd0);
    tick();
    chk("ar_rel_busy2", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dds_sweep_ctrl
`default_nettype wire
